// File: rtl/bp_update_queue.sv
// bp_update_queue: in-order branch queue releasing resolved, committed branches as two-phase predictor updates
module bp_update_queue #(
    parameter int DEPTH     = 8,
    parameter int NUM_IN    = 2,
    parameter int SQN_W     = 7,
    parameter int FETCHID_W = 3,
    parameter int FOFF_W    = 3,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   IN_allocValid,
    input  logic [SQN_W-1:0]       IN_allocSqN,
    input  logic [FETCHID_W-1:0]   IN_allocFetchID,
    input  logic [FOFF_W-1:0]      IN_allocFetchOffs,
    input  logic [30:0]            IN_allocPC,
    output logic [IW-1:0]          OUT_allocIdx,
    output logic                   OUT_full,
    input  logic [NUM_IN-1:0]      IN_resValid,
    input  logic [NUM_IN*IW-1:0]   IN_resIdx,
    input  logic [NUM_IN-1:0]      IN_resTaken,
    input  logic [SQN_W-1:0]       IN_comSqN,
    input  logic                   IN_flush,
    input  logic [SQN_W-1:0]       IN_flushSqN,
    output logic                   OUT_upd0Valid,
    output logic [FETCHID_W-1:0]   OUT_upd0FetchID,
    output logic [FOFF_W-1:0]      OUT_upd0FetchOffs,
    output logic                   OUT_upd0Taken,
    output logic                   OUT_upd1Valid,
    output logic [30:0]            OUT_upd1PC
);
    logic [DEPTH-1:0]     valid, valid_n, resolved, taken, flushed;
    logic [SQN_W-1:0]     sqn [DEPTH];
    logic [FETCHID_W-1:0] fid [DEPTH];
    logic [FOFF_W-1:0]    foffs [DEPTH];
    logic [30:0]          pc [DEPTH];
    logic [IW-1:0]        head, tail, tail_n;
    logic [30:0]          upd0_pc;
    logic                 rel, alloc_ok, found;
    logic [SQN_W-1:0]     com_diff;

    // a is strictly younger than b in wrapping sequence-number space
    function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return !d[SQN_W-1] && (d != '0);
    endfunction

    assign OUT_allocIdx = tail;
    assign alloc_ok     = IN_allocValid && !OUT_full && !IN_flush;
    assign com_diff     = sqn[head] - IN_comSqN;
    assign rel          = valid[head] && resolved[head] && com_diff[SQN_W-1];

    // next occupancy: release at head, flush of younger entries, alloc at tail; new tail after flush
    always_comb begin
        valid_n = valid;
        tail_n  = tail;
        found   = 1'b0;
        flushed = '0;
        for (int i = 0; i < DEPTH; i++)
            flushed[i] = IN_flush && valid[i] && younger(sqn[i], IN_flushSqN);
        for (int k = 0; k < DEPTH; k++)
            if (!found && flushed[head + IW'(k)]) begin
                tail_n = head + IW'(k);
                found  = 1'b1;
            end
        if (rel) valid_n[head] = 1'b0;
        valid_n = valid_n & ~flushed;
        if (alloc_ok) begin
            valid_n[tail] = 1'b1;
            tail_n        = tail + 1'b1;
        end
    end

    // queue state, entry payloads, resolves and the two-stage update pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            head          <= '0;
            tail          <= '0;
            OUT_full      <= 1'b0;
            OUT_upd0Valid <= 1'b0;
            OUT_upd1Valid <= 1'b0;
        end else begin
            valid         <= valid_n;
            tail          <= tail_n;
            head          <= head + IW'(rel);
            OUT_full      <= &valid_n;
            OUT_upd0Valid <= rel;
            OUT_upd1Valid <= OUT_upd0Valid;
            OUT_upd1PC    <= upd0_pc;
            if (rel) begin
                OUT_upd0FetchID   <= fid[head];
                OUT_upd0FetchOffs <= foffs[head];
                OUT_upd0Taken     <= taken[head];
                upd0_pc           <= pc[head];
            end
            for (int p = 0; p < NUM_IN; p++)
                if (IN_resValid[p] && valid[IN_resIdx[p*IW +: IW]]) begin
                    resolved[IN_resIdx[p*IW +: IW]] <= 1'b1;
                    taken[IN_resIdx[p*IW +: IW]]    <= IN_resTaken[p];
                end
            if (alloc_ok) begin
                resolved[tail] <= 1'b0;
                sqn[tail]      <= IN_allocSqN;
                fid[tail]      <= IN_allocFetchID;
                foffs[tail]    <= IN_allocFetchOffs;
                pc[tail]       <= IN_allocPC;
            end
        end
    end
endmodule

// File: tb/tb_bp_update_queue.sv
// tb_bp_update_queue: directed self-checking bench for bp_update_queue
module tb_bp_update_queue;
    logic        clk = 0, rst = 1;
    logic        IN_allocValid = 0;
    logic [6:0]  IN_allocSqN = 0;
    logic [2:0]  IN_allocFetchID = 0, IN_allocFetchOffs = 0;
    logic [30:0] IN_allocPC = 0;
    logic [2:0]  OUT_allocIdx;
    logic        OUT_full;
    logic [1:0]  IN_resValid = 0, IN_resTaken = 0;
    logic [5:0]  IN_resIdx = 0;
    logic [6:0]  IN_comSqN = 0, IN_flushSqN = 0;
    logic        IN_flush = 0;
    logic        OUT_upd0Valid, OUT_upd0Taken, OUT_upd1Valid;
    logic [2:0]  OUT_upd0FetchID, OUT_upd0FetchOffs;
    logic [30:0] OUT_upd1PC;
    int          n_tests = 0, n_fail = 0;

    bp_update_queue dut (
        .clk(clk), .rst(rst),
        .IN_allocValid(IN_allocValid), .IN_allocSqN(IN_allocSqN),
        .IN_allocFetchID(IN_allocFetchID), .IN_allocFetchOffs(IN_allocFetchOffs),
        .IN_allocPC(IN_allocPC), .OUT_allocIdx(OUT_allocIdx), .OUT_full(OUT_full),
        .IN_resValid(IN_resValid), .IN_resIdx(IN_resIdx), .IN_resTaken(IN_resTaken),
        .IN_comSqN(IN_comSqN), .IN_flush(IN_flush), .IN_flushSqN(IN_flushSqN),
        .OUT_upd0Valid(OUT_upd0Valid), .OUT_upd0FetchID(OUT_upd0FetchID),
        .OUT_upd0FetchOffs(OUT_upd0FetchOffs), .OUT_upd0Taken(OUT_upd0Taken),
        .OUT_upd1Valid(OUT_upd1Valid), .OUT_upd1PC(OUT_upd1PC)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic alloc(input int s, input int f, input int o, input int p);
        IN_allocValid = 1; IN_allocSqN = 7'(s); IN_allocFetchID = 3'(f);
        IN_allocFetchOffs = 3'(o); IN_allocPC = 31'(p);
        tick();
        IN_allocValid = 0;
    endtask

    task automatic res2(input logic v0, input int i0, input logic t0,
                        input logic v1, input int i1, input logic t1);
        IN_resValid = {v1, v0}; IN_resIdx = {3'(i1), 3'(i0)}; IN_resTaken = {t1, t0};
        tick();
        IN_resValid = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_full", OUT_full, 0);
        chk("rst_upd0v", OUT_upd0Valid, 0);
        chk("rst_upd1v", OUT_upd1Valid, 0);
        chk("rst_idx", OUT_allocIdx, 0);

        // single branch: sqn 5 released as two-phase update
        alloc(5, 2, 1, 'h100);
        IN_comSqN = 6;
        res2(1, 0, 1, 0, 0, 0);
        chk("t1_noupd_yet", OUT_upd0Valid, 0);
        tick();
        chk("t1_upd0v", OUT_upd0Valid, 1);
        chk("t1_fid", OUT_upd0FetchID, 2);
        chk("t1_offs", OUT_upd0FetchOffs, 1);
        chk("t1_taken", OUT_upd0Taken, 1);
        chk("t1_upd1v_early", OUT_upd1Valid, 0);
        tick();
        chk("t1_upd1v", OUT_upd1Valid, 1);
        chk("t1_pc", OUT_upd1PC, 'h100);
        chk("t1_upd0v_off", OUT_upd0Valid, 0);

        // in-order: younger resolved first, held until the oldest resolves
        IN_comSqN = 13;
        alloc(10, 1, 0, 'h10);
        alloc(11, 2, 0, 'h11);
        alloc(12, 3, 0, 'h12);
        res2(1, 2, 0, 1, 2, 1);
        res2(1, 3, 0, 0, 0, 0);
        tick();
        chk("t2_hold", OUT_upd0Valid, 0);
        res2(0, 0, 0, 1, 1, 1);
        tick();
        chk("t2_a_v", OUT_upd0Valid, 1);
        chk("t2_a_fid", OUT_upd0FetchID, 1);
        tick();
        chk("t2_b_fid", OUT_upd0FetchID, 2);
        chk("t2_b_taken", OUT_upd0Taken, 1);
        chk("t2_b_pc", OUT_upd1PC, 'h10);
        chk("t2_b_both", {OUT_upd0Valid, OUT_upd1Valid}, 2'b11);
        tick();
        chk("t2_c_fid", OUT_upd0FetchID, 3);
        chk("t2_c_taken", OUT_upd0Taken, 0);
        chk("t2_c_pc", OUT_upd1PC, 'h11);
        tick();
        chk("t2_d_upd0v", OUT_upd0Valid, 0);
        chk("t2_d_pc", OUT_upd1PC, 'h12);

        // fill, dropped 9th alloc, release frees one slot
        do_reset();
        IN_comSqN = 13;
        for (int s = 30; s < 38; s++) alloc(s, s & 7, 0, s);
        chk("t3_full", OUT_full, 1);
        chk("t3_wrap_idx", OUT_allocIdx, 0);
        alloc(38, 6, 0, 38);
        chk("t3_drop_idx", OUT_allocIdx, 0);
        chk("t3_drop_full", OUT_full, 1);
        IN_comSqN = 31;
        res2(1, 0, 1, 0, 0, 0);
        tick();
        chk("t3_notfull", OUT_full, 0);
        chk("t3_rel_fid", OUT_upd0FetchID, 6);
        chk("t3_idx0", OUT_allocIdx, 0);
        alloc(38, 6, 0, 38);
        chk("t3_refill_idx", OUT_allocIdx, 1);
        chk("t3_refull", OUT_full, 1);

        // flush younger than 21; concurrent alloc dropped; resolve to flushed slot ignored
        do_reset();
        IN_comSqN = 0;
        for (int s = 20; s < 25; s++) alloc(s, s & 7, 0, s);
        IN_flush = 1; IN_flushSqN = 21;
        alloc(25, 1, 0, 25);
        IN_flush = 0;
        chk("t4_tail", OUT_allocIdx, 2);
        chk("t4_full", OUT_full, 0);
        IN_comSqN = 30;
        res2(1, 0, 1, 1, 1, 0);
        res2(1, 2, 1, 0, 0, 0);
        chk("t4_a_fid", OUT_upd0FetchID, 4);
        chk("t4_a_taken", OUT_upd0Taken, 1);
        tick();
        chk("t4_b_fid", OUT_upd0FetchID, 5);
        tick();
        chk("t4_c_none", OUT_upd0Valid, 0);

        // sequence-number wrap
        do_reset();
        IN_comSqN = 1;
        alloc(126, 6, 0, 126);
        alloc(127, 7, 0, 127);
        alloc(0, 0, 0, 0);
        res2(1, 0, 1, 1, 1, 1);
        res2(1, 2, 1, 0, 0, 0);
        chk("t5_a_v", OUT_upd0Valid, 1);
        chk("t5_a_fid", OUT_upd0FetchID, 6);
        tick();
        chk("t5_b_fid", OUT_upd0FetchID, 7);
        chk("t5_b_pc", OUT_upd1PC, 126);
        tick();
        chk("t5_c_v", OUT_upd0Valid, 1);
        chk("t5_c_fid", OUT_upd0FetchID, 0);
        chk("t5_c_pc", OUT_upd1PC, 127);

        // reset while upd0 valid suppresses upd1
        tick();
        IN_comSqN = 3;
        alloc(2, 5, 0, 2);
        res2(1, 3, 1, 0, 0, 0);
        tick();
        chk("t6_upd0v", OUT_upd0Valid, 1);
        rst = 1;
        tick();
        chk("t6_upd1v", OUT_upd1Valid, 0);
        chk("t6_upd0v_off", OUT_upd0Valid, 0);
        chk("t6_full", OUT_full, 0);
        chk("t6_idx", OUT_allocIdx, 0);
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
